// File: rtl/bp_me_pkg.sv
// Shared types for the CCE mem_cmd admission gate.
package bp_me_pkg;

  typedef enum logic [0:0] {
    e_wait_calib,
    e_run
  } bp_me_cmd_gate_state_e;

endpackage

// File: rtl/bp_me_cmd_gate_fifo.sv
// Two-entry queue: ready-valid on input, valid-yumi on output.
// ready_o depends only on registered state, so there is no input-to-ready path.
module bp_me_cmd_gate_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem_q [2];
  logic               wptr_q, wptr_d;
  logic               rptr_q, rptr_d;
  logic [1:0]         count_q, count_d;
  logic               init_q;
  logic               enq, deq;

  // init_q keeps ready low while reset is held and releases it one edge later
  assign ready_o = init_q & (count_q != 2'd2);
  assign v_o     = (count_q != 2'd0);
  assign data_o  = mem_q[rptr_q];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + {1'b0, enq} - {1'b0, deq};
    if (enq) wptr_d = ~wptr_q;
    if (deq) rptr_d = ~rptr_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= '0;
      init_q  <= 1'b0;
    end else begin
      if (enq) mem_q[wptr_q] <= data_i;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      init_q  <= 1'b1;
    end
  end

endmodule

// File: rtl/bp_me_mem_cmd_gate.sv
// Holds CCE memory commands until DDR calibration has been stable long enough,
// and caps in-flight commands so the converter's tag FIFO cannot overflow.
module bp_me_mem_cmd_gate
  import bp_me_pkg::*;
#(
  parameter int mem_msg_width_p       = 32,
  parameter int max_outstanding_p     = 4,
  parameter int calib_stable_cycles_p = 16,
  localparam int out_width_lp         = $clog2(max_outstanding_p + 1),
  localparam int stable_width_lp      = $clog2(calib_stable_cycles_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [mem_msg_width_p-1:0] mem_cmd_i,
  input  logic                       mem_cmd_v_i,
  output logic                       mem_cmd_ready_o,
  output logic [mem_msg_width_p-1:0] mem_cmd_o,
  output logic                       mem_cmd_v_o,
  input  logic                       mem_cmd_yumi_i,
  input  logic                       mem_resp_v_i,
  input  logic                       mem_resp_yumi_i,
  input  logic                       calib_complete_i,
  output logic                       calib_done_o,
  output logic [out_width_lp-1:0]    outstanding_o
);

  localparam logic [stable_width_lp-1:0] stable_max_lp  = stable_width_lp'(calib_stable_cycles_p);
  localparam logic [stable_width_lp-1:0] stable_last_lp = stable_width_lp'(calib_stable_cycles_p - 1);
  localparam logic [out_width_lp-1:0]    out_max_lp     = out_width_lp'(max_outstanding_p);
  localparam logic [out_width_lp-1:0]    out_one_lp     = out_width_lp'(1);

  bp_me_cmd_gate_state_e state_q, state_d;
  logic [stable_width_lp-1:0] stable_q, stable_d;
  logic [out_width_lp-1:0]    out_q, out_d;
  logic                       fifo_v;
  logic                       resp_hs;

  bp_me_cmd_gate_fifo #(
    .width_p (mem_msg_width_p)
  ) fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (mem_cmd_i),
    .v_i     (mem_cmd_v_i),
    .ready_o (mem_cmd_ready_o),
    .data_o  (mem_cmd_o),
    .v_o     (fifo_v),
    .yumi_i  (mem_cmd_yumi_i)
  );

  assign resp_hs       = mem_resp_v_i & mem_resp_yumi_i;
  assign calib_done_o  = (state_q == e_run);
  assign outstanding_o = out_q;
  assign mem_cmd_v_o   = fifo_v & (state_q == e_run) & (out_q < out_max_lp);

  always_comb begin
    stable_d = stable_q;
    if (!calib_complete_i)             stable_d = '0;
    else if (stable_q != stable_max_lp) stable_d = stable_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      e_wait_calib: if (calib_complete_i && stable_q == stable_last_lp) state_d = e_run;
      e_run:        if (!calib_complete_i) state_d = e_wait_calib;
      default:      state_d = e_wait_calib;
    endcase
  end

  // Issue and response in the same cycle cancel; a stray response at zero is held.
  always_comb begin
    out_d = out_q;
    case ({mem_cmd_yumi_i, resp_hs})
      2'b10:   out_d = out_q + out_one_lp;
      2'b01:   if (out_q != '0) out_d = out_q - out_one_lp;
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= e_wait_calib;
      stable_q <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      stable_q <= stable_d;
      out_q    <= out_d;
    end
  end

  resp_underflow_a: assert property (@(posedge clk_i) disable iff (reset_i)
    !(resp_hs && !mem_cmd_yumi_i && out_q == '0))
    else $error("response handshake with no command outstanding");

endmodule

// File: tb/tb_bp_me_mem_cmd_gate.sv
// Directed bench for bp_me_mem_cmd_gate: calibration gating, outstanding cap,
// ordering, calibration loss and asynchronous reset.
module tb_bp_me_mem_cmd_gate;

  localparam int W = 16;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [W-1:0]  mem_cmd_i;
  logic          mem_cmd_v_i;
  logic          mem_cmd_ready_o;
  logic [W-1:0]  mem_cmd_o;
  logic          mem_cmd_v_o;
  logic          mem_cmd_yumi_i;
  logic          mem_resp_v_i;
  logic          mem_resp_yumi_i;
  logic          calib_complete_i;
  logic          calib_done_o;
  logic [2:0]    outstanding_o;

  int errors = 0;
  int checks = 0;

  bp_me_mem_cmd_gate #(
    .mem_msg_width_p       (W),
    .max_outstanding_p     (4),
    .calib_stable_cycles_p (16)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .mem_cmd_i        (mem_cmd_i),
    .mem_cmd_v_i      (mem_cmd_v_i),
    .mem_cmd_ready_o  (mem_cmd_ready_o),
    .mem_cmd_o        (mem_cmd_o),
    .mem_cmd_v_o      (mem_cmd_v_o),
    .mem_cmd_yumi_i   (mem_cmd_yumi_i),
    .mem_resp_v_i     (mem_resp_v_i),
    .mem_resp_yumi_i  (mem_resp_yumi_i),
    .calib_complete_i (calib_complete_i),
    .calib_done_o     (calib_done_o),
    .outstanding_o    (outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; mem_cmd_i = '0; mem_cmd_v_i = 1'b0; mem_cmd_yumi_i = 1'b0;
    mem_resp_v_i = 1'b0; mem_resp_yumi_i = 1'b0; calib_complete_i = 1'b0;
    #2;
    checks++; if (mem_cmd_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", mem_cmd_ready_o); end
    checks++; if (mem_cmd_v_o !== 1'b0) begin errors++; $display("FAIL reset_v: got %b want 0", mem_cmd_v_o); end
    checks++; if (calib_done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", calib_done_o); end
    checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL reset_outst: got %0d want 0", outstanding_o); end
    tick(); tick();
    reset_i = 1'b0;
    tick();
    checks++; if (mem_cmd_ready_o !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", mem_cmd_ready_o); end
  endtask

  task automatic test_prefill();
    mem_cmd_i = 16'h00A0; mem_cmd_v_i = 1'b1;
    tick();
    checks++; if (mem_cmd_v_o !== 1'b0) begin errors++; $display("FAIL prefill_v1: got %b want 0", mem_cmd_v_o); end
    mem_cmd_i = 16'h00B0;
    tick();
    checks++; if (mem_cmd_ready_o !== 1'b0) begin errors++; $display("FAIL prefill_full: got %b want 0", mem_cmd_ready_o); end
    mem_cmd_i = 16'h00C0;
    tick();
    checks++; if (mem_cmd_ready_o !== 1'b0) begin errors++; $display("FAIL prefill_c_held: got %b want 0", mem_cmd_ready_o); end
    checks++; if (mem_cmd_v_o !== 1'b0) begin errors++; $display("FAIL prefill_v3: got %b want 0", mem_cmd_v_o); end
    mem_cmd_v_i = 1'b0;
  endtask

  task automatic test_calib();
    calib_complete_i = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (calib_done_o !== 1'b0) begin errors++; $display("FAIL calib_15_high: got %b want 0", calib_done_o); end
    calib_complete_i = 1'b0;
    tick();
    checks++; if (calib_done_o !== 1'b0) begin errors++; $display("FAIL calib_dip: got %b want 0", calib_done_o); end
    calib_complete_i = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (calib_done_o !== 1'b0) begin errors++; $display("FAIL calib_15_again: got %b want 0", calib_done_o); end
    checks++; if (mem_cmd_v_o !== 1'b0) begin errors++; $display("FAIL calib_v_early: got %b want 0", mem_cmd_v_o); end
    tick();
    checks++; if (calib_done_o !== 1'b1) begin errors++; $display("FAIL calib_16th: got %b want 1", calib_done_o); end
    checks++; if (mem_cmd_v_o !== 1'b1) begin errors++; $display("FAIL calib_issue_v: got %b want 1", mem_cmd_v_o); end
    checks++; if (mem_cmd_o !== 16'h00A0) begin errors++; $display("FAIL calib_head: got %h want 00a0", mem_cmd_o); end
  endtask

  task automatic test_outstanding();
    logic [W-1:0] exp_list [6];
    int idx, ycnt;
    logic enq;
    exp_list[0] = 16'h00A0; exp_list[1] = 16'h00B0; exp_list[2] = 16'h00C0;
    exp_list[3] = 16'h00D0; exp_list[4] = 16'h00E0; exp_list[5] = 16'h00F0;
    idx = 2; ycnt = 0;
    for (int c = 0; c < 10; c++) begin
      mem_cmd_yumi_i = mem_cmd_v_o;
      if (mem_cmd_v_o) begin
        checks++; if (mem_cmd_o !== exp_list[ycnt]) begin errors++; $display("FAIL cap_order[%0d]: got %h want %h", ycnt, mem_cmd_o, exp_list[ycnt]); end
        ycnt++;
      end
      mem_cmd_v_i = (idx < 6);
      mem_cmd_i   = (idx < 6) ? exp_list[idx] : '0;
      enq = mem_cmd_v_i & mem_cmd_ready_o;
      tick();
      if (enq) idx++;
    end
    mem_cmd_yumi_i = 1'b0; mem_cmd_v_i = 1'b0;
    checks++; if (ycnt != 4) begin errors++; $display("FAIL cap_yumis: got %0d want 4", ycnt); end
    checks++; if (outstanding_o !== 3'd4) begin errors++; $display("FAIL cap_outst: got %0d want 4", outstanding_o); end
    checks++; if (mem_cmd_v_o !== 1'b0) begin errors++; $display("FAIL cap_v: got %b want 0", mem_cmd_v_o); end
    mem_resp_v_i = 1'b1; mem_resp_yumi_i = 1'b1;
    tick();
    mem_resp_v_i = 1'b0; mem_resp_yumi_i = 1'b0;
    checks++; if (outstanding_o !== 3'd3) begin errors++; $display("FAIL resp_outst: got %0d want 3", outstanding_o); end
    checks++; if (mem_cmd_v_o !== 1'b1) begin errors++; $display("FAIL resp_reissue_v: got %b want 1", mem_cmd_v_o); end
    checks++; if (mem_cmd_o !== 16'h00E0) begin errors++; $display("FAIL resp_head: got %h want 00e0", mem_cmd_o); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] stream [4];
    int sidx, ycnt, first_c, last_c;
    logic enq;
    stream[0] = 16'h1A1A; stream[1] = 16'h2B2B; stream[2] = 16'h3C3C; stream[3] = 16'h4D4D;
    mem_resp_v_i = 1'b1; mem_resp_yumi_i = 1'b1;
    tick();
    mem_resp_v_i = 1'b0; mem_resp_yumi_i = 1'b0;
    checks++; if (outstanding_o !== 3'd2) begin errors++; $display("FAIL simul_pre: got %0d want 2", outstanding_o); end
    mem_cmd_yumi_i = mem_cmd_v_o; mem_resp_v_i = 1'b1; mem_resp_yumi_i = 1'b1;
    tick();
    mem_cmd_yumi_i = 1'b0; mem_resp_v_i = 1'b0; mem_resp_yumi_i = 1'b0;
    checks++; if (outstanding_o !== 3'd2) begin errors++; $display("FAIL simul_outst: got %0d want 2", outstanding_o); end
    checks++; if (mem_cmd_o !== 16'h00F0) begin errors++; $display("FAIL simul_head: got %h want 00f0", mem_cmd_o); end
    // drain F with a matching response so the count stays at 2
    mem_cmd_yumi_i = mem_cmd_v_o; mem_resp_v_i = mem_cmd_v_o; mem_resp_yumi_i = mem_cmd_v_o;
    tick();
    sidx = 0; ycnt = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 8; c++) begin
      mem_cmd_yumi_i = mem_cmd_v_o; mem_resp_v_i = mem_cmd_v_o; mem_resp_yumi_i = mem_cmd_v_o;
      if (mem_cmd_v_o) begin
        checks++; if (ycnt >= 4 || mem_cmd_o !== stream[ycnt & 3]) begin errors++; $display("FAIL b2b_order[%0d]: got %h want %h", ycnt, mem_cmd_o, stream[ycnt & 3]); end
        if (first_c < 0) first_c = c;
        last_c = c;
        ycnt++;
      end
      mem_cmd_v_i = (sidx < 4);
      mem_cmd_i   = (sidx < 4) ? stream[sidx] : '0;
      enq = mem_cmd_v_i & mem_cmd_ready_o;
      tick();
      if (enq) sidx++;
    end
    mem_cmd_yumi_i = 1'b0; mem_resp_v_i = 1'b0; mem_resp_yumi_i = 1'b0; mem_cmd_v_i = 1'b0;
    checks++; if (ycnt != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", ycnt); end
    checks++; if (last_c - first_c != 3) begin errors++; $display("FAIL b2b_rate: got span %0d want 3", last_c - first_c); end
    checks++; if (outstanding_o !== 3'd2) begin errors++; $display("FAIL b2b_outst: got %0d want 2", outstanding_o); end
  endtask

  task automatic test_calib_loss_and_reset();
    mem_cmd_v_i = 1'b1; mem_cmd_i = 16'h5050;
    tick();
    mem_cmd_i = 16'h6060;
    tick();
    mem_cmd_v_i = 1'b0;
    checks++; if (mem_cmd_v_o !== 1'b1) begin errors++; $display("FAIL loss_pre_v: got %b want 1", mem_cmd_v_o); end
    checks++; if (mem_cmd_ready_o !== 1'b0) begin errors++; $display("FAIL loss_pre_full: got %b want 0", mem_cmd_ready_o); end
    calib_complete_i = 1'b0;
    tick();
    checks++; if (mem_cmd_v_o !== 1'b0) begin errors++; $display("FAIL loss_v: got %b want 0", mem_cmd_v_o); end
    checks++; if (calib_done_o !== 1'b0) begin errors++; $display("FAIL loss_done: got %b want 0", calib_done_o); end
    checks++; if (mem_cmd_ready_o !== 1'b0) begin errors++; $display("FAIL loss_buffer: got %b want 0", mem_cmd_ready_o); end
    mem_resp_v_i = 1'b1; mem_resp_yumi_i = 1'b1;
    tick();
    mem_resp_v_i = 1'b0; mem_resp_yumi_i = 1'b0;
    checks++; if (outstanding_o !== 3'd1) begin errors++; $display("FAIL loss_resp: got %0d want 1", outstanding_o); end
    calib_complete_i = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (mem_cmd_v_o !== 1'b0) begin errors++; $display("FAIL recal_early_v: got %b want 0", mem_cmd_v_o); end
    tick();
    checks++; if (mem_cmd_v_o !== 1'b1) begin errors++; $display("FAIL recal_v: got %b want 1", mem_cmd_v_o); end
    checks++; if (mem_cmd_o !== 16'h5050) begin errors++; $display("FAIL recal_head: got %h want 5050", mem_cmd_o); end
    #3;
    reset_i = 1'b1;
    #1;
    checks++; if (mem_cmd_v_o !== 1'b0) begin errors++; $display("FAIL async_rst_v: got %b want 0", mem_cmd_v_o); end
    checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL async_rst_outst: got %0d want 0", outstanding_o); end
    checks++; if (calib_done_o !== 1'b0) begin errors++; $display("FAIL async_rst_done: got %b want 0", calib_done_o); end
    checks++; if (mem_cmd_ready_o !== 1'b0) begin errors++; $display("FAIL async_rst_ready: got %b want 0", mem_cmd_ready_o); end
    tick();
    reset_i = 1'b0;
    tick();
    checks++; if (mem_cmd_ready_o !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", mem_cmd_ready_o); end
    checks++; if (mem_cmd_v_o !== 1'b0) begin errors++; $display("FAIL post_rst_empty: got %b want 0", mem_cmd_v_o); end
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_calib();
    test_outstanding();
    test_back_to_back();
    test_calib_loss_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
